axi_sram_slave: RTL

AXI4 subset slave (responder) backed by an internal word-wide SRAM array; it is the far end of the LSU/IFU AXI master interfaces. It serves one transaction at a time (read or write), supports INCR bursts, byte strobes and a programmable response delay for latency stress. It replaces the DPI memory model in simulation-only subsystems and sits behind the crossbar as the main-memory responder.

---
 rtl/axi_pkg.sv | 28 ++
 rtl/axi_slave_mem.sv | 26 ++
 rtl/axi_sram_slave.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/axi_pkg.sv
// Shared AXI encodings and slave FSM state type for the SRAM responder.
package axi_pkg;

    localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_R_DELAY = 3'd1,
        S_R_DATA  = 3'd2,
        S_W_DATA  = 3'd3,
        S_W_DELAY = 3'd4,
        S_B_RESP  = 3'd5
    } state_e;

    // Encodings order by severity, so the worst code is the larger value.
    function automatic logic [1:0] resp_worst(input logic [1:0] a,
                                              input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/axi_slave_mem.sv
// Word-wide SRAM array: combinational read, synchronous byte-strobe write.
module axi_slave_mem #(
    parameter int WORDS = 4096,
    parameter int AW    = $clog2(WORDS)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [3:0]    wstrb_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem [WORDS];

    assign rdata_o = mem[addr_i];

    always_ff @(posedge clk_i) begin
        for (int b = 0; b < 4; b++) begin
            if (we_i && wstrb_i[b]) begin
                mem[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
    end

endmodule

// File: rtl/axi_sram_slave.sv
// AXI4-subset SRAM responder: one transaction at a time, INCR bursts,
// byte strobes and a fixed response delay.
module axi_sram_slave
    import axi_pkg::*;
#(
    parameter logic [31:0] MEM_BASE   = 32'h8000_0000,
    parameter int          MEM_WORDS  = 4096,
    parameter int          RESP_DELAY = 2
) (
    input  logic        clk_i,
    input  logic        rst,
    input  logic [3:0]  arid_i,
    input  logic [31:0] araddr_i,
    input  logic [7:0]  arlen_i,
    input  logic [2:0]  arsize_i,
    input  logic [1:0]  arburst_i,
    input  logic        arvalid_i,
    output logic        arready_o,
    output logic [3:0]  rid_o,
    output logic [31:0] rdata_o,
    output logic [1:0]  rresp_o,
    output logic        rlast_o,
    output logic        rvalid_o,
    input  logic        rready_i,
    input  logic [3:0]  awid_i,
    input  logic [31:0] awaddr_i,
    input  logic [7:0]  awlen_i,
    input  logic [2:0]  awsize_i,
    input  logic [1:0]  awburst_i,
    input  logic        awvalid_i,
    output logic        awready_o,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  wstrb_i,
    input  logic        wlast_i,
    input  logic        wvalid_i,
    output logic        wready_o,
    output logic [3:0]  bid_o,
    output logic [1:0]  bresp_o,
    output logic        bvalid_o,
    input  logic        bready_i
);

    localparam int          AW        = $clog2(MEM_WORDS);
    localparam logic [31:0] MEM_BYTES = 32'(MEM_WORDS * 4);
    localparam int          CW        = (RESP_DELAY > 1) ? $clog2(RESP_DELAY) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(RESP_DELAY - 1);

    state_e        state_q, state_d;
    logic [3:0]    id_q, id_d;
    logic [31:0]   addr_q, addr_d;
    logic [7:0]    len_q, len_d;
    logic [7:0]    beat_q, beat_d;
    logic [2:0]    size_q, size_d;
    logic          berr_q, berr_d;
    logic [1:0]    wresp_q, wresp_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [31:0] offset;
    logic [31:0] step;
    logic [1:0]  beat_resp;
    logic        last_beat;
    logic        mem_we;
    logic [31:0] mem_rdata;

    assign offset    = addr_q - MEM_BASE;
    assign step      = (size_q > 3'd2) ? 32'd4 : (32'd1 << size_q[1:0]);
    assign last_beat = (beat_q == len_q);

    // Out-of-range beats decode-error even inside a bad-burst transaction.
    assign beat_resp = (offset >= MEM_BYTES) ? AXI_RESP_DECERR :
                       berr_q                ? AXI_RESP_SLVERR :
                                               AXI_RESP_OKAY;

    axi_slave_mem #(.WORDS(MEM_WORDS), .AW(AW)) u_mem (
        .clk_i  (clk_i),
        .we_i   (mem_we),
        .addr_i (offset[AW+1:2]),
        .wstrb_i(wstrb_i),
        .wdata_i(wdata_i),
        .rdata_o(mem_rdata)
    );

    always_comb begin
        state_d   = state_q;
        id_d      = id_q;
        addr_d    = addr_q;
        len_d     = len_q;
        beat_d    = beat_q;
        size_d    = size_q;
        berr_d    = berr_q;
        wresp_d   = wresp_q;
        cnt_d     = cnt_q;
        mem_we    = 1'b0;
        arready_o = 1'b0;
        awready_o = 1'b0;
        wready_o  = 1'b0;
        rvalid_o  = 1'b0;
        rid_o     = '0;
        rdata_o   = '0;
        rresp_o   = AXI_RESP_OKAY;
        rlast_o   = 1'b0;
        bvalid_o  = 1'b0;
        bid_o     = '0;
        bresp_o   = AXI_RESP_OKAY;
        unique case (state_q)
            S_IDLE: begin
                arready_o = ~rst;
                awready_o = ~rst & ~arvalid_i;
                if (arvalid_i) begin
                    id_d    = arid_i;
                    addr_d  = araddr_i;
                    len_d   = arlen_i;
                    size_d  = arsize_i;
                    berr_d  = (arburst_i != AXI_BURST_INCR);
                    beat_d  = '0;
                    cnt_d   = CNT_LOAD;
                    state_d = (RESP_DELAY == 0) ? S_R_DATA : S_R_DELAY;
                end else if (awvalid_i) begin
                    id_d    = awid_i;
                    addr_d  = awaddr_i;
                    len_d   = awlen_i;
                    size_d  = awsize_i;
                    berr_d  = (awburst_i != AXI_BURST_INCR);
                    beat_d  = '0;
                    wresp_d = AXI_RESP_OKAY;
                    state_d = S_W_DATA;
                end
            end
            S_R_DELAY: begin
                if (cnt_q == '0) state_d = S_R_DATA;
                else             cnt_d   = cnt_q - 1'b1;
            end
            S_R_DATA: begin
                rvalid_o = 1'b1;
                rid_o    = id_q;
                rresp_o  = beat_resp;
                rlast_o  = last_beat;
                rdata_o  = (beat_resp == AXI_RESP_OKAY) ? mem_rdata : '0;
                if (rready_i) begin
                    if (last_beat) begin
                        state_d = S_IDLE;
                    end else begin
                        beat_d = beat_q + 8'd1;
                        addr_d = addr_q + step;
                    end
                end
            end
            S_W_DATA: begin
                wready_o = 1'b1;
                if (wvalid_i) begin
                    mem_we  = (beat_resp == AXI_RESP_OKAY);
                    wresp_d = resp_worst(wresp_q, beat_resp);
                    if (wlast_i != last_beat) begin
                        wresp_d = resp_worst(wresp_d, AXI_RESP_SLVERR);
                    end
                    if (wlast_i || last_beat) begin
                        cnt_d   = CNT_LOAD;
                        state_d = (RESP_DELAY == 0) ? S_B_RESP : S_W_DELAY;
                    end else begin
                        beat_d = beat_q + 8'd1;
                        addr_d = addr_q + step;
                    end
                end
            end
            S_W_DELAY: begin
                if (cnt_q == '0) state_d = S_B_RESP;
                else             cnt_d   = cnt_q - 1'b1;
            end
            S_B_RESP: begin
                bvalid_o = 1'b1;
                bid_o    = id_q;
                bresp_o  = wresp_q;
                if (bready_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst) begin
            state_q <= S_IDLE;
            id_q    <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            beat_q  <= '0;
            size_q  <= '0;
            berr_q  <= 1'b0;
            wresp_q <= AXI_RESP_OKAY;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            beat_q  <= beat_d;
            size_q  <= size_d;
            berr_q  <= berr_d;
            wresp_q <= wresp_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
